// File: rtl/switch_count_display.sv
// rtl/switch_count_display.sv - push-button press counter on a 4-digit multiplexed common-anode display
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most-significant non-zero digit)
module switch_count_display #(
  parameter int c_SCAN_DIV = 50_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Switch,
  input  logic        i_Clear,
  output logic [15:0] o_Count,
  output logic [6:0]  o_Segment,
  output logic [3:0]  o_Digit
);

  localparam int SCAN_W = $clog2(c_SCAN_DIV);

  logic              switch_d;
  logic [15:0]       count;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic              press;
  logic [3:0]        sel_digit;
  logic              blank;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign press   = i_Switch & ~switch_d;
  assign o_Count = count;

  always_comb begin
    sel_digit = 4'd0;
    blank     = 1'b0;
    case (digit_idx)
      2'd0:    sel_digit = count[3:0];
      2'd1:    sel_digit = count[7:4];
      2'd2:    sel_digit = count[11:8];
      default: sel_digit = count[15:12];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // The ones digit is never blanked, so zero still shows a single "0".
    case (digit_idx)
      2'd1:    blank = (count[15:4] == 12'd0);
      2'd2:    blank = (count[15:8] == 8'd0);
      2'd3:    blank = (count[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      switch_d  <= 1'b0;
      count     <= 16'h0000;
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      o_Segment <= 7'h7F;
      o_Digit   <= 4'b1111;
    end else begin
      // Edge register updates even while clearing, so a coincident press is consumed.
      switch_d <= i_Switch;
      if (i_Clear) begin
        count <= 16'h0000;
      end else if (press) begin
        count <= bcd_inc(count);
      end

      if (scan_cnt == SCAN_W'(c_SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      o_Segment <= blank ? 7'h7F : seg_decode(sel_digit);
      o_Digit   <= ~(4'b0001 << digit_idx);
    end
  end

endmodule

// File: tb/tb_switch_count_display.sv
// tb/tb_switch_count_display.sv - self-checking bench for switch_count_display with a behavioural model
`timescale 1ns/1ps
module tb_switch_count_display;

  localparam int SCAN = 4;

  logic        clk;
  logic        rst_n;
  logic        sw;
  logic        clr;
  logic [15:0] count;
  logic [6:0]  seg;
  logic [3:0]  dig;

  int checks = 0;
  int errors = 0;

  switch_count_display #(.c_SCAN_DIV(SCAN)) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Switch  (sw),
    .i_Clear   (clr),
    .o_Count   (count),
    .o_Segment (seg),
    .o_Digit   (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural model: decimal count, edge count since reset, table lookup for segments.
  int       m_count;
  int       m_cyc;
  bit       m_prev;
  bit       model_valid = 0;
  logic [6:0] m_seg;
  logic [3:0] m_dig;
  logic [6:0] seg_tab [10];
  int       pow10 [4];

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    pow10   = '{1, 10, 100, 1000};
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    int idx;
    int val;
    bit blk;
    if (!rst_n) begin
      m_count = 0;
      m_prev  = 0;
      m_cyc   = 0;
      m_seg   = 7'h7F;
      m_dig   = 4'hF;
      model_valid = 1;
    end else if (model_valid) begin
      idx = (m_cyc / SCAN) % 4;
      val = (m_count / pow10[idx]) % 10;
      blk = 0;
`ifdef LEADING_ZERO_BLANK_EN
      blk = (idx > 0) && (m_count < pow10[idx]);
`endif
      m_seg = blk ? 7'h7F : seg_tab[val];
      m_dig = 4'hF & ~(4'b0001 << idx);
      m_cyc++;
      if (clr) m_count = 0;
      else if (sw && !m_prev) m_count = (m_count + 1) % 10000;
      m_prev = sw;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks += 3;
      if (count !== to_bcd(m_count)) begin
        errors++;
        $display("FAIL model_count t=%0t got %h want %h", $time, count, to_bcd(m_count));
      end
      if (seg !== m_seg) begin
        errors++;
        $display("FAIL model_segment t=%0t got %h want %h", $time, seg, m_seg);
      end
      if (dig !== m_dig) begin
        errors++;
        $display("FAIL model_digit t=%0t got %b want %b", $time, dig, m_dig);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic press();
    sw = 1'b1;
    step();
    sw = 1'b0;
    step();
  endtask

  task automatic presses(input int n);
    for (int i = 0; i < n; i++) press();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_digit(input logic [3:0] pat);
    int k;
    for (k = 0; k < 20; k++) begin
      if (dig == pat) break;
      step();
    end
    checks++;
    if (dig != pat) begin
      errors++;
      $display("FAIL wait_digit got %b want %b", dig, pat);
    end
  endtask

  initial begin
    logic [3:0] scan_pat [4];
    scan_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst_n = 1'b0;
    sw    = 1'b0;
    clr   = 1'b0;

    // Reset state and scan sequence
    repeat (3) step();
    check_eq("reset_count", count, 16'h0000);
    check_eq("reset_segment", seg, 7'h7F);
    check_eq("reset_digit", dig, 4'b1111);
    rst_n = 1'b1;
    step();
    check_eq("first_digit", dig, 4'b1110);
    check_eq("first_segment", seg, 7'h40);
    for (int c = 1; c < 16; c++) begin
      step();
      check_eq("scan_sequence", dig, scan_pat[c / 4]);
    end

    // Single held press
    sw = 1'b1;
    step();
    check_eq("held_press_first", count, 16'h0001);
    repeat (99) step();
    check_eq("held_press_stays", count, 16'h0001);
    wait_digit(4'b1110);
    check_eq("ones_shows_1", seg, 7'h79);
    sw = 1'b0;
    step();
    check_eq("release_no_change", count, 16'h0001);

    // BCD carry and wrap
    do_clear();
    presses(9);
    check_eq("nine", count, 16'h0009);
    press();
    check_eq("ten", count, 16'h0010);
    wait_digit(4'b1101);
    check_eq("tens_shows_1", seg, 7'h79);
    do_clear();
    presses(9999);
    check_eq("preload_9999", count, 16'h9999);
    press();
    check_eq("wrap_0000", count, 16'h0000);

    // Clear beats a coincident press; holding does not re-count
    presses(5);
    check_eq("five", count, 16'h0005);
    clr = 1'b1;
    sw  = 1'b1;
    step();
    clr = 1'b0;
    check_eq("clear_priority", count, 16'h0000);
    repeat (10) step();
    check_eq("press_consumed", count, 16'h0000);
    sw = 1'b0;
    step();

    // Reset mid-operation with a coincident press
    presses(123);
    check_eq("count_0123", count, 16'h0123);
    rst_n = 1'b0;
    sw    = 1'b1;
    step();
    check_eq("midreset_count", count, 16'h0000);
    check_eq("midreset_digit", dig, 4'b1111);
    rst_n = 1'b1;
    sw    = 1'b0;
    step();
    check_eq("midreset_scan_restart", dig, 4'b1110);

    // Leading-zero display
    presses(42);
    check_eq("count_0042", count, 16'h0042);
    wait_digit(4'b0111);
`ifdef LEADING_ZERO_BLANK_EN
    check_eq("d3_of_42", seg, 7'h7F);
`else
    check_eq("d3_of_42", seg, 7'h40);
`endif
    wait_digit(4'b1110);
    check_eq("d0_of_42", seg, 7'h24);
    wait_digit(4'b1101);
    check_eq("d1_of_42", seg, 7'h19);
    wait_digit(4'b1011);
`ifdef LEADING_ZERO_BLANK_EN
    check_eq("d2_of_42", seg, 7'h7F);
`else
    check_eq("d2_of_42", seg, 7'h40);
`endif
    do_clear();
    wait_digit(4'b1110);
    check_eq("zero_d0", seg, 7'h40);
    wait_digit(4'b1101);
`ifdef LEADING_ZERO_BLANK_EN
    check_eq("zero_d1", seg, 7'h7F);
`else
    check_eq("zero_d1", seg, 7'h40);
`endif

    // Randomised traffic, checked by the model process
    for (int i = 0; i < 4000; i++) begin
      sw    = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 63) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    clr   = 1'b0;
    sw    = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_count_display.md
# switch_count_display

Counts presses of a debounced push-button and shows the running total on a four-digit, multiplexed, common-anode seven-segment display. It sits directly downstream of the switch debouncer and takes the debouncer's clean level as `i_Switch`. It drives the board's segment and digit-enable pins directly. Internally it holds a 4-digit BCD counter, a rising-edge detector, a digit-scan timer and a registered segment decoder.

## Interface
Parameters:
- `c_SCAN_DIV`, default 50_000: clock cycles each digit stays enabled (1 ms at 50 MHz); legal range 2 to 2^20.

Ports:
- `i_Clk`, in, 1: system clock; all logic is rising-edge.
- `i_Rst_n`, in, 1: reset, synchronous, active-low.
- `i_Switch`, in, 1: debounced switch level; 1 means pressed. It is already synchronous to `i_Clk`.
- `i_Clear`, in, 1: synchronous clear of the count. Level-sensitive.
- `o_Count`, out, 16: current count as packed BCD, `{thousands, hundreds, tens, ones}`.
- `o_Segment`, out, 7: segment drive `{g,f,e,d,c,b,a}`, active-low.
- `o_Digit`, out, 4: digit enables, active-low; bit 0 is the ones digit.

## Operation
- **Reset.** While `i_Rst_n`=0 at a clock edge, all state clears:
  - count = 0x0000, edge register = 0, scan counter = 0, digit index = 0;
  - `o_Segment` = 7'h7F (all segments off);
  - `o_Digit` = 4'b1111 (all digits off).
  - Reset asserted mid-operation overrides everything, including a pending increment or clear.
- **Edge detect.** `r_Switch_d` registers `i_Switch` every cycle. An increment occurs when `i_Switch`=1 and `r_Switch_d`=0.
  - Exactly one increment per press, regardless of how long the switch is held.
  - Releasing the switch does nothing.
- **Count.** Four BCD digits with ripple carry. A digit at 9 rolls to 0 and carries into the next digit.
  - 9999 + 1 wraps to 0000; there is no overflow flag.
  - Digits never hold values A–F.
- **Clear.** `i_Clear`=1 loads 0000. If a clear and an increment occur in the same cycle, the clear wins (result 0000).
  - The edge register still updates while clearing, so a press that coincides with a clear is consumed, not deferred.
- **Scan timer.**
  - The scan counter counts 0 to `c_SCAN_DIV`-1 and then wraps.
  - On the wrap, the digit index advances 0→1→2→3→0.
- **Decode.** Each cycle, the selected BCD digit of the current count is decoded. `o_Segment` and `o_Digit` are registered together.
  - Active-low patterns: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - `o_Digit` is one-hot-low at the current index.

## Timing
- `o_Count` changes at the same clock edge that samples the rising `i_Switch`. It is visible one cycle after `i_Switch` is first seen high.
- `o_Segment`/`o_Digit` lag the count and the digit index by one register stage (latency 1 cycle).
- First edge after reset release:
  - `o_Digit` = 4'b1110;
  - `o_Segment` = the decode of the ones digit of 0000, i.e. 7'h40.
- Each digit is enabled for exactly `c_SCAN_DIV` cycles; a full refresh takes 4×`c_SCAN_DIV` cycles.
- A count change while a digit is displayed appears on that digit on the next cycle. There is no wait for the next scan.
- No handshake: presses spaced ≥2 cycles apart (1→0→1) are each counted.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Any digit above the most-significant non-zero digit drives 7'h7F while enabled. Its `o_Digit` timing is unchanged.
  - The ones digit is always displayed, so a count of 0 shows a single "0".
  - Blanking is evaluated on the same cycle as the decode (no extra latency).
- `LEADING_ZERO_BLANK_EN` undefined: all four digits are always decoded, e.g. 0042 shows as "0042".
- `o_Count` is identical in both builds.

## Test plan
Bench uses `c_SCAN_DIV`=4.
1. **Reset.** Hold `i_Rst_n`=0 for 3 cycles, then release → during reset `o_Segment`=7F, `o_Digit`=1111, `o_Count`=0000. On the first edge after release `o_Digit`=1110 and `o_Segment`=40. The digit sequence is then 1110, 1101, 1011, 0111, with each enable lasting 4 cycles.
2. **Single press, held.** Raise `i_Switch`, hold it for 100 cycles, then lower it → `o_Count`=0001 one cycle after the rise and stays 0001. While `o_Digit`=1110, `o_Segment`=79.
3. **BCD carry and wrap.** Apply 9 presses → 0009. Apply 1 more → 0010 (tens digit shows 79). Preload via 9999 presses, then 1 more → 9999 → 0000.
4. **Clear priority.** With count 0005, raise `i_Switch` in the same cycle `i_Clear`=1 → `o_Count`=0000, not 0001. Holding the switch without releasing it adds nothing.
5. **Reset mid-operation.** At count 0123, pulse `i_Rst_n`=0 for 1 cycle coincident with a press → `o_Count`=0000, `o_Digit`=1111 in that cycle, and the scan restarts at the ones digit.
6. **Leading-zero blanking.** Count 0042.
   - With `LEADING_ZERO_BLANK_EN`: digit-3 and digit-2 slots drive 7F, digit 1 drives 19, digit 0 drives 24.
   - Without it: digits 3 and 2 drive 40.
   - Count 0000 with the macro: only digit 0 shows 40.
